// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: default widths and the counter size.
package debounce_pkg;

  localparam int unsigned DEFAULT_WIDTH           = 7;
  // 10 ms at 100 MHz. Legal range is 2 .. 2^24-1, bounded by CNT_W.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned CNT_W                   = 24;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter, debounced level and edge pulses.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic             clean_d;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == LAST_CNT) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH board switches and reports each change of the clean word
// through a single-entry valid/ready event register with a sticky overrun flag.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             chg_valid,
  input  logic             chg_ready,
  output logic [WIDTH-1:0] chg_data,
  output logic             chg_overrun
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_raw[i]),
      .clean_o(sw_clean[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

  logic             change;
  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             ovr_q;
  logic             ovr_d;

  assign change = |(sw_rise | sw_fall);

  // Handshake: an event transfers on a cycle with chg_valid && chg_ready.
  // chg_valid/chg_data never drop or change while unaccepted, except that a
  // newer change replaces the word (and flags overrun if it was not being taken).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (change) begin
      valid_d = 1'b1;
      data_d  = sw_clean;
      if (valid_q && !chg_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && chg_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign chg_valid   = valid_q;
  assign chg_data    = data_q;
  assign chg_overrun = ovr_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// checked cycle by cycle against a window-based reference model.
module tb_switch_debouncer;

  localparam int W  = 7;
  localparam int N  = 4;
  localparam int EW = 4 * W + 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         chg_valid;
  logic         chg_ready;
  logic [W-1:0] chg_data;
  logic         chg_overrun;

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .chg_valid  (chg_valid),
    .chg_ready  (chg_ready),
    .chg_data   (chg_data),
    .chg_overrun(chg_overrun)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bit's clean level flips at edge t when the raw samples
  // taken at edges t-N-1 .. t-2 all disagree with it and its last flip was at
  // least N edges ago. Raw samples before reset release count as 0.
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  hist[$];
  int            edge_n;
  int            last_flip[W];
  logic [W-1:0]  m_clean, m_rise, m_fall, m_data;
  logic          m_valid, m_ovr, m_chg;

  function automatic logic [W-1:0] samp(input int k);
    if (k < 1) return '0;
    return hist[k-1];
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] nxt;
    logic [W-1:0] s;
    logic         stable;
    if (!rst_n) begin
      edge_n = 0;
      hist.delete();
      for (int b = 0; b < W; b++) last_flip[b] = 0;
      m_clean = '0; m_rise = '0; m_fall = '0; m_data = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_chg = 1'b0;
    end else begin
      edge_n++;
      hist.push_back(sw_raw);
      if (m_chg) begin
        if (m_valid && !chg_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = m_clean;
      end else if (m_valid && chg_ready) begin
        m_valid = 1'b0;
      end
      nxt = m_clean;
      for (int b = 0; b < W; b++) begin
        if (edge_n - last_flip[b] >= N) begin
          stable = 1'b1;
          for (int k = edge_n - N - 1; k <= edge_n - 2; k++) begin
            s = samp(k);
            if (s[b] == m_clean[b]) stable = 1'b0;
          end
          if (stable) begin
            nxt[b]       = ~m_clean[b];
            last_flip[b] = edge_n;
          end
        end
      end
      m_rise  = nxt & ~m_clean;
      m_fall  = ~nxt & m_clean;
      m_chg   = (nxt != m_clean);
      m_clean = nxt;
    end
    exp_q.push_back({m_clean, m_rise, m_fall, m_valid, m_data, m_ovr});
  end

  // Monitor: compares every cycle's outputs against the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'({sw_clean, sw_rise, sw_fall, chg_valid, chg_data, chg_overrun}), 32'(e));
    end
  end

  // Accepted-event recorder for the handshake scenario.
  logic         rec_en = 1'b0;
  logic [W-1:0] ev_q[$];
  always @(negedge clk) begin
    if (rec_en && chg_valid && chg_ready) ev_q.push_back(chg_data);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] raw_after);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero",
          32'({sw_clean, sw_rise, sw_fall, chg_valid, chg_data, chg_overrun}), 32'(0));
    sw_raw = raw_after;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_raw    = '0;
    chg_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({sw_clean, chg_valid, chg_data, chg_overrun}), 32'(0));
    #1;
    rst_n = 1'b1;

    // Single bit accepted after N+2 edges, event one edge later
    do_reset('0);
    chg_ready = 1'b0;
    tick();
    sw_raw = 7'h01;
    repeat (5) tick();
    check("a_clean_before_window", 32'(sw_clean), 32'h00);
    tick();
    check("a_clean_at_n_plus_2", 32'(sw_clean), 32'h01);
    check("a_rise_pulse", 32'(sw_rise), 32'h01);
    tick();
    check("a_rise_single_cycle", 32'(sw_rise), 32'h00);
    check("a_event_valid", 32'(chg_valid), 32'h1);
    check("a_event_data", 32'(chg_data), 32'h01);
    chg_ready = 1'b1;
    tick();
    check("a_event_accepted", 32'(chg_valid), 32'h0);

    // Short glitch is ignored
    do_reset('0);
    tick();
    sw_raw = 7'h04;
    repeat (3) tick();
    sw_raw = 7'h00;
    repeat (12) tick();
    check("b_glitch_clean", 32'(sw_clean), 32'h00);
    check("b_glitch_no_event", 32'(chg_valid), 32'h0);

    // Overwrite while pending sets overrun
    do_reset('0);
    chg_ready = 1'b0;
    tick();
    sw_raw = 7'h02;
    repeat (20) tick();
    sw_raw = 7'h0A;
    repeat (20) tick();
    check("c_data_latest", 32'(chg_data), 32'h0A);
    check("c_valid_held", 32'(chg_valid), 32'h1);
    check("c_overrun_set", 32'(chg_overrun), 32'h1);

    // Always-ready consumer sees two separate events
    do_reset('0);
    chg_ready = 1'b1;
    ev_q.delete();
    rec_en = 1'b1;
    tick();
    sw_raw = 7'h10;
    repeat (10) tick();
    sw_raw = 7'h00;
    repeat (20) tick();
    rec_en = 1'b0;
    check("d_event_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() == 2) begin
      check("d_event0_data", 32'(ev_q[0]), 32'h10);
      check("d_event1_data", 32'(ev_q[1]), 32'h00);
    end
    check("d_no_overrun", 32'(chg_overrun), 32'h0);

    // Reset mid-pending-event and mid-count, then all switches high
    do_reset('0);
    chg_ready = 1'b0;
    tick();
    sw_raw = 7'h01;
    repeat (10) tick();
    sw_raw = 7'h7F;
    repeat (3) tick();
    do_reset(7'h7F);
    repeat (N + 1) tick();
    check("e_clean_before_window", 32'(sw_clean), 32'h00);
    tick();
    check("e_clean_all_high", 32'(sw_clean), 32'h7F);
    check("e_rise_all", 32'(sw_rise), 32'h7F);
    tick();
    check("e_event_after_reset", 32'({chg_valid, chg_data}), 32'({1'b1, 7'h7F}));

    // Random activity, scoreboard only
    for (int c = 0; c < 800; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
      chg_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) do_reset(W'($urandom_range(0, 127)));
    end
    for (int c = 0; c < 700; c++) begin
      tick();
      if ($urandom_range(0, 1) == 0) sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, 1));
      chg_ready = ($urandom_range(0, 1) != 0);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 7; number of switch inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; stable cycles required before accepting a level (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port sw_raw, input, WIDTH bits; asynchronous board switch levels.
REQ-006 SHALL have port sw_clean, output, WIDTH bits; debounced switch levels.
REQ-007 SHALL have port sw_rise, output, WIDTH bits; one-cycle pulse per bit when sw_clean goes 0->1.
REQ-008 SHALL have port sw_fall, output, WIDTH bits; one-cycle pulse per bit when sw_clean goes 1->0.
REQ-009 SHALL have port chg_valid, output, 1 bit; a change event is pending.
REQ-010 SHALL have port chg_ready, input, 1 bit; consumer accepts the event.
REQ-011 SHALL have port chg_data, output, WIDTH bits; sw_clean word captured at the latest change.
REQ-012 SHALL have port chg_overrun, output, 1 bit; sticky flag: an event was overwritten before acceptance.

Function
REQ-013 SHALL pass each sw_raw bit through a 2-flop synchronizer before any other logic.
REQ-014 SHALL keep one counter per bit; counter clears whenever the synchronized bit equals sw_clean.
REQ-015 SHALL increment the counter each cycle the synchronized bit differs from sw_clean.
REQ-016 SHALL, on a cycle where the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, load sw_clean with the synchronized bit and clear the counter.
REQ-017 SHALL make sw_clean follow a raw change held stable for the full window exactly DEBOUNCE_CYCLES+2 clock edges after the change.
REQ-018 SHALL ignore any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles; the counter restarts from 0 on the next difference.
REQ-019 SHALL assert sw_rise/sw_fall in the same cycle the corresponding sw_clean bit changes, for exactly one cycle.
REQ-020 SHALL treat bits independently; several bits may update in the same cycle.
REQ-021 SHALL, on any cycle where at least one sw_clean bit changes, load chg_data with the new sw_clean word and set chg_valid on the next edge.
REQ-022 SHALL hold chg_valid and chg_data stable while chg_valid=1 and chg_ready=0, except per REQ-023.
REQ-023 SHALL, if a new change arrives while chg_valid=1 and chg_ready=0, overwrite chg_data with the newer word, keep chg_valid=1, and set chg_overrun.
REQ-024 SHALL, on chg_valid=1 and chg_ready=1 without a new change, clear chg_valid on the next edge.
REQ-025 SHALL, on chg_valid=1, chg_ready=1 and a new change in the same cycle, load the new word, keep chg_valid=1, and not set chg_overrun.
REQ-026 SHALL ignore chg_ready while chg_valid=0.
REQ-027 SHALL clear chg_overrun only by reset.

Reset
REQ-028 SHALL, on rst_n low, immediately force synchronizers, counters, sw_clean, sw_rise, sw_fall, chg_valid, chg_data and chg_overrun to 0.
REQ-029 SHALL, on rst_n release with switches high, report them through the normal debounce path (sw_rise and a change event after DEBOUNCE_CYCLES+2 edges).
REQ-030 SHALL abandon any partial count or pending event when reset asserts mid-operation.

Structure
REQ-031 SHALL place the default DEBOUNCE_CYCLES, counter width (24) and WIDTH default in shared package debounce_pkg.
REQ-032 SHALL implement the per-bit synchronizer, counter and edge pulses in sub-module debounce_bit, instantiated WIDTH times; the change handshake lives in the top.

Verification
REQ-033 SHALL cover: DEBOUNCE_CYCLES=4, sw_raw[0] 0->1 held -> sw_clean[0]=1 and sw_rise[0] pulse exactly 6 edges later, chg_valid=1 next edge with chg_data=7'h01.
REQ-034 SHALL cover: DEBOUNCE_CYCLES=4, sw_raw[2] high for 3 cycles then low -> sw_clean stays 7'h00, no pulses, chg_valid stays 0.
REQ-035 SHALL cover: chg_ready=0, bit 1 then bit 3 rise 20 cycles apart -> chg_data=7'h0A, chg_valid=1, chg_overrun=1.
REQ-036 SHALL cover: chg_ready=1 held, bit 4 rises and 10 cycles later falls -> two single-cycle chg_valid events with chg_data 7'h10 then 7'h00, chg_overrun=0.
REQ-037 SHALL cover: rst_n pulsed low mid-count and mid-pending-event -> all outputs 0 immediately; with sw_raw=7'h7F held, sw_clean=7'h7F DEBOUNCE_CYCLES+2 edges after release.
